// File: rtl/hexa7seg_scan_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hexa7seg_scan_if: value/control inputs and scanned display outputs     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface hexa7seg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic                  load;
    logic [4*N_DIGITS-1:0] valor;
    logic                  blank_lz;
    logic [N_DIGITS-1:0]   blink_en;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   digit_sel;
    logic                  frame_tick;

    modport master (
        output load, valor, blank_lz, blink_en,
        input  seg, digit_sel, frame_tick
    );

    modport slave (
        input  load, valor, blank_lz, blink_en,
        output seg, digit_sel, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/hexa7seg_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hexa7seg_scan: multiplexed hex 7-segment driver with LZ blank + blink  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module hexa7seg_scan #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    hexa7seg_scan_if.slave  bus
);
    localparam int c_pw = $clog2(SCAN_DIV);
    localparam int c_iw = $clog2(N_DIGITS);
    localparam int c_fw = $clog2(BLINK_FRAMES + 1);

    localparam logic [c_pw-1:0]     c_presc_last  = c_pw'(SCAN_DIV - 1);
    localparam logic [c_iw-1:0]     c_idx_last    = c_iw'(N_DIGITS - 1);
    localparam logic [c_fw-1:0]     c_frames_last = c_fw'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] c_one         = N_DIGITS'(1);

    logic [c_pw-1:0]       r_presc;
    logic [c_iw-1:0]       r_idx;
    logic [c_fw-1:0]       r_frames;
    logic                  r_phase;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic [6:0]            r_seg;
    logic [N_DIGITS-1:0]   r_sel;
    logic                  r_wrap;
    logic                  r_tick;

    logic                  w_slot_end;
    logic                  w_wrap;
    logic [3:0]            w_digit;
    logic                  w_upper_zero;
    logic                  w_blank;
    logic [6:0]            w_next_seg;

    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        w_slot_end   = (r_presc == c_presc_last);
        w_wrap       = w_slot_end && (r_idx == c_idx_last);
        w_digit      = r_shadow[4*int'(r_idx) +: 4];
        // Current digit and everything above it zero means it is a leading zero.
        w_upper_zero = ((r_shadow >> (4*int'(r_idx))) == '0);
        w_blank      = (bus.blank_lz && (r_idx != '0) && w_upper_zero)
                    || (bus.blink_en[r_idx] && r_phase);
        w_next_seg   = w_blank ? 7'h00 : font(w_digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_frames <= '0;
            r_phase  <= 1'b0;
            r_shadow <= '0;
            r_seg    <= 7'h00;
            r_sel    <= '0;
            r_wrap   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
            if (w_slot_end) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
            if (w_wrap) begin
                if (r_frames == c_frames_last) begin
                    r_frames <= '0;
                    r_phase  <= ~r_phase;
                end else begin
                    r_frames <= r_frames + 1'b1;
                end
            end
            if (bus.load) begin
                r_shadow <= bus.valor;
            end
            r_seg  <= w_next_seg;
            r_sel  <= c_one << r_idx;
            // Delayed one cycle so the pulse lines up with digit_sel returning to digit 0.
            r_wrap <= w_wrap;
            r_tick <= r_wrap;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.digit_sel  = r_sel;
    assign bus.frame_tick = r_tick;
endmodule
`default_nettype wire

// File: tb/tb_hexa7seg_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_hexa7seg_scan: self-checking bench, 4 digits, 4-cycle slots         |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_hexa7seg_scan;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hexa7seg_scan_if #(.N_DIGITS(4)) bus ();

    hexa7seg_scan #(
        .N_DIGITS    (4),
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    int          edges    = 0;
    logic [15:0] sh_m     = '0;
    logic [6:0]  font_m [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // c = clock edges since reset release before the edge producing this output
    function automatic logic [6:0] model_seg(input int c, input logic [15:0] sh,
                                             input logic blz, input logic [3:0] ben);
        int          idx   = (c / 4) % 4;
        int          phase = (c / 16 / 2) % 2;
        logic [15:0] up    = sh >> (4 * idx);
        logic        blank = (blz && idx > 0 && up == 16'h0) || (ben[idx] && phase == 1);
        return blank ? 7'h00 : font_m[up[3:0]];
    endfunction

    task automatic step();
        int         idx      = (edges / 4) % 4;
        logic [6:0] exp_seg  = model_seg(edges, sh_m, bus.blank_lz, bus.blink_en);
        logic [3:0] exp_sel  = 4'(1 << idx);
        logic       exp_tick = (edges >= 16) && (edges % 16 == 0);
        @(posedge clk);
        if (bus.load) sh_m = bus.valor;
        edges++;
        #1;
        chk("seg", 32'(bus.seg), 32'(exp_seg));
        chk("digit_sel", 32'(bus.digit_sel), 32'(exp_sel));
        chk("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_val(input logic [15:0] v);
        bus.valor = v;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    initial begin
        bus.load     = 1'b1;
        bus.valor    = 16'hFFFF;
        bus.blank_lz = 1'b0;
        bus.blink_en = 4'b0000;

        // Reset state, with load held high to show it is ignored
        #23;
        chk("rst_seg", 32'(bus.seg), 32'h0);
        chk("rst_sel", 32'(bus.digit_sel), 32'h0);
        chk("rst_tick", 32'(bus.frame_tick), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        bus.load = 1'b0;
        edges    = 0;
        sh_m     = '0;

        // Free run: first output 3F on digit 0, frame_tick every 16 cycles
        run(40);

        load_val(16'h1A3F);
        run(32);

        bus.blank_lz = 1'b1;
        load_val(16'h0005);
        run(20);
        load_val(16'h0000);
        run(20);
        load_val(16'h0300);
        run(20);

        bus.blank_lz = 1'b0;
        bus.blink_en = 4'b0010;
        load_val(16'h8888);
        run(80);

        // load held high re-captures every cycle, including on slot ends
        bus.load = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.valor = 16'($urandom);
            step();
        end
        bus.load = 1'b0;

        // Randomized operation
        for (int i = 0; i < 400; i++) begin
            bus.load     = ($urandom_range(0, 5) == 0);
            bus.valor    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            bus.blank_lz = 1'($urandom);
            bus.blink_en = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            step();
        end
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.blink_en = 4'b0000;

        // Asynchronous reset in the middle of digit 2's slot
        for (int i = 0; i < 16 && (edges % 16) != 9; i++) step();
        #2;
        rst_n     = 1'b0;
        bus.load  = 1'b1;
        bus.valor = 16'hABCD;
        #1;
        chk("async_rst_seg", 32'(bus.seg), 32'h0);
        chk("async_rst_sel", 32'(bus.digit_sel), 32'h0);
        chk("async_rst_tick", 32'(bus.frame_tick), 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_seg", 32'(bus.seg), 32'h0);
        chk("held_rst_sel", 32'(bus.digit_sel), 32'h0);
        rst_n    = 1'b1;
        bus.load = 1'b0;
        edges    = 0;
        sh_m     = '0;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
